// File: rtl/mips_multicycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips_multicycle_core : multicycle MIPS-32 core, one shared memory port
// Rev 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RET_CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [31:0]          nextPC,
  output logic [31:0]          ula_result,
  output logic [31:0]          data_mem,
  output logic                 retired,
  output logic [RET_CNT_W-1:0] ret_count,
  output logic                 trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'h00, c_op_j    = 6'h02, c_op_jal  = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04, c_op_bne  = 6'h05, c_op_addi = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09, c_op_slti = 6'h0A, c_op_andi = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D, c_op_lw   = 6'h23, c_op_sw   = 6'h2B;
  localparam logic [5:0] c_fn_sll   = 6'h00, c_fn_srl  = 6'h02, c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_add   = 6'h20, c_fn_sub  = 6'h22, c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25, c_fn_slt  = 6'h2A;
  localparam logic [RET_CNT_W-1:0] c_ret_one = RET_CNT_W'(1);

  state_t               r_state;
  logic [31:0]          r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
  logic [31:0]          r_regs [32];
  logic [RET_CNT_W-1:0] r_ret_cnt;
  logic                 r_retired, r_trap;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_dst;
  logic [15:0] w_imm;
  logic [25:0] w_target;
  logic [31:0] w_sext, w_zext, w_alu_b, w_alu_res, w_wb_data;
  logic        w_rtype, w_rtype_ok, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
  logic        w_is_j, w_is_jal, w_is_alui, w_is_logic_imm, w_legal, w_take;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_shamt  = r_ir[10:6];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = r_ir[15:0];
  assign w_target = r_ir[25:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};

  assign w_rtype        = (w_op == c_op_rtype);
  assign w_rtype_ok     = w_funct inside {c_fn_sll, c_fn_srl, c_fn_jr, c_fn_add,
                                          c_fn_sub, c_fn_and, c_fn_or, c_fn_slt};
  assign w_is_jr        = w_rtype && (w_funct == c_fn_jr);
  assign w_is_lw        = (w_op == c_op_lw);
  assign w_is_sw        = (w_op == c_op_sw);
  assign w_is_beq       = (w_op == c_op_beq);
  assign w_is_bne       = (w_op == c_op_bne);
  assign w_is_j         = (w_op == c_op_j);
  assign w_is_jal       = (w_op == c_op_jal);
  assign w_is_logic_imm = (w_op == c_op_andi) || (w_op == c_op_ori);
  assign w_is_alui      = w_op inside {c_op_addi, c_op_addiu, c_op_slti, c_op_andi, c_op_ori};
  assign w_legal        = (w_rtype && w_rtype_ok) || w_is_alui || w_is_lw || w_is_sw ||
                          w_is_beq || w_is_bne || w_is_j || w_is_jal;
  assign w_take         = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));

  // andi/ori take a zero-extended immediate; everything else sign-extends
  assign w_alu_b = w_rtype ? r_b : (w_is_logic_imm ? w_zext : w_sext);

  always_comb begin
    w_alu_res = r_a + w_alu_b;
    if (w_rtype) begin
      case (w_funct)
        c_fn_sub: w_alu_res = r_a - r_b;
        c_fn_and: w_alu_res = r_a & r_b;
        c_fn_or:  w_alu_res = r_a | r_b;
        c_fn_slt: w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
        c_fn_sll: w_alu_res = r_b << w_shamt;
        c_fn_srl: w_alu_res = r_b >> w_shamt;
        default:  ;
      endcase
    end else begin
      case (w_op)
        c_op_andi: w_alu_res = r_a & w_alu_b;
        c_op_ori:  w_alu_res = r_a | w_alu_b;
        c_op_slti: w_alu_res = {31'd0, $signed(r_a) < $signed(w_alu_b)};
        default:   ;
      endcase
    end
  end

  assign w_wb_dst  = w_rtype ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_ret_cnt <= '0;
      r_retired <= 1'b0;
      r_trap    <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_retired <= 1'b0;
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a       <= r_regs[w_rs];
          r_b       <= r_regs[w_rt];
          r_alu_out <= r_pc + (w_sext << 2);
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_lw || w_is_sw) begin
            r_alu_out <= w_alu_res;
            r_state   <= S_MEM;
          end else if ((w_rtype && !w_is_jr) || w_is_alui) begin
            r_alu_out <= w_alu_res;
            r_state   <= S_WB;
          end else begin
            if (w_take)                  r_pc <= r_alu_out;
            else if (w_is_j || w_is_jal) r_pc <= {r_pc[31:28], w_target, 2'b00};
            else if (w_is_jr)            r_pc <= r_a;
            if (w_is_jal) r_regs[31] <= r_pc;
            r_ret_cnt <= r_ret_cnt + c_ret_one;
            r_retired <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_MEM: if (mem_ready) begin
          if (w_is_lw) begin
            r_mdr   <= mem_rdata;
            r_state <= S_WB;
          end else begin
            r_ret_cnt <= r_ret_cnt + c_ret_one;
            r_retired <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_wb_data;
          r_ret_cnt <= r_ret_cnt + c_ret_one;
          r_retired <= 1'b1;
          r_state   <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Request is qualified by reset so it drops the instant reset falls
  assign mem_req    = reset && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_we     = (r_state == S_MEM) && w_is_sw;
  assign mem_addr   = {(r_state == S_MEM) ? r_alu_out[31:2] : r_pc[31:2], 2'b00};
  assign mem_wdata  = r_b;
  assign nextPC     = r_pc;
  assign ula_result = r_alu_out;
  assign data_mem   = r_mdr;
  assign retired    = r_retired;
  assign ret_count  = r_ret_cnt;
  assign trap       = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mips_multicycle_core : scoreboard bench, directed program with a stalling memory model
module tb_mips_multicycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, retired, trap;
  logic [31:0] mem_addr, mem_wdata, nextPC, ula_result, data_mem, ret_count;
  logic        u2_mem_req, u2_mem_we, u2_retired, u2_trap;
  logic [31:0] u2_mem_addr, u2_mem_wdata, u2_nextPC, u2_ula_result, u2_data_mem;
  logic [1:0]  u2_ret_count;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  always #5 clock = ~clock;

  mips_multicycle_core #(.RESET_PC(32'h0), .RET_CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .nextPC(nextPC), .ula_result(ula_result),
    .data_mem(data_mem), .retired(retired), .ret_count(ret_count), .trap(trap)
  );

  // Narrow-counter copy runs in lockstep on the same memory responses
  mips_multicycle_core #(.RESET_PC(32'h0), .RET_CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .mem_req(u2_mem_req), .mem_we(u2_mem_we),
    .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .nextPC(u2_nextPC), .ula_result(u2_ula_result),
    .data_mem(u2_data_mem), .retired(u2_retired), .ret_count(u2_ret_count), .trap(u2_trap)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc, alu, mdr, cnt;
  } ret_t;
  typedef struct {
    logic [31:0] addr, data;
  } wr_t;

  ret_t exp_q[$];
  wr_t  wr_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   data_stall = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_ret(input int c, input logic [31:0] pc, alu, mdr, cnt);
    ret_t r;
    r.cyc = c; r.pc = pc; r.alu = alu; r.mdr = mdr; r.cnt = cnt;
    exp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("first_fetch_addr", mem_addr, 32'h0);
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
    mem[0]  = 32'h2001_0005; // addi $1,$0,5
    mem[1]  = 32'h2002_FFFD; // addi $2,$0,-3
    mem[2]  = 32'h0022_1820; // add  $3,$1,$2
    mem[3]  = 32'hAC03_0008; // sw   $3,8($0)
    mem[4]  = 32'h8C04_0008; // lw   $4,8($0)
    mem[5]  = 32'hAC04_0080; // sw   $4,0x80($0)
    mem[6]  = 32'h1422_0002; // bne  $1,$2,+2 (taken)
    mem[9]  = 32'h1022_0005; // beq  $1,$2,+5 (not taken)
    mem[10] = 32'h1021_0001; // beq  $1,$1,+1 (taken)
    mem[12] = 32'h0C00_0040; // jal  0x40
    mem[13] = 32'h3405_8001; // ori  $5,$0,0x8001
    mem[14] = 32'h0041_302A; // slt  $6,$2,$1
    mem[15] = 32'h0001_3900; // sll  $7,$1,4
    mem[64] = 32'hAC1F_0080; // sw   $31,0x80($0)
    mem[65] = 32'h03E0_0008; // jr   $31
  endtask

  initial begin
    int   wcnt;
    int   need;
    logic pend;
    logic [31:0] h_addr, h_wdata;
    logic h_we;
    bit   found;

    load_program();
    #1 reset = 1'b0;

    fork
      // memory responder: fetches are always ready, data accesses stall data_stall cycles
      begin
        wcnt = 0;
        forever begin
          @(negedge clock);
          if (reset && mem_req) begin
            need = (mem_addr != nextPC) ? data_stall : 0;
            if (wcnt >= need) begin
              mem_ready = 1'b1;
              wcnt = 0;
              if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            end else begin
              mem_ready = 1'b0;
              wcnt++;
            end
          end else begin
            mem_ready = 1'b0;
            wcnt = 0;
          end
        end
      end
      // monitor: counts cycles since reset release, checks retirements, writes and request stability
      begin
        pend = 1'b0;
        forever begin
          @(posedge clock);
          if (!reset) cyc = 0; else cyc++;
          @(negedge clock);
          #1;
          if (!reset) begin
            pend = 1'b0;
          end else begin
            if (pend) begin
              chk("hold_req", {31'd0, mem_req}, 32'd1);
              chk("hold_addr", mem_addr, h_addr);
              chk("hold_we", {31'd0, mem_we}, {31'd0, h_we});
              chk("hold_wdata", mem_wdata, h_wdata);
            end
            pend = mem_req && !mem_ready;
            h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
            if (mem_req && mem_we && mem_ready) begin
              if (wr_q.size() == 0) fail_now("unexpected_write");
              else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
              end
            end
            if (retired) begin
              if (exp_q.size() == 0) fail_now("unexpected_retire");
              else begin
                ret_t e;
                e = exp_q.pop_front();
                chk("ret_cycle", cyc, e.cyc);
                chk("ret_pc", nextPC, e.pc);
                chk("ret_alu", ula_result, e.alu);
                chk("ret_mdr", data_mem, e.mdr);
                chk("ret_count", ret_count, e.cnt);
                chk("ret_count_w2", {30'd0, u2_ret_count}, {30'd0, e.cnt[1:0]});
              end
            end
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_pc", nextPC, 32'h0);
    chk("rst_alu", ula_result, 32'h0);
    chk("rst_mdr", data_mem, 32'h0);
    chk("rst_cnt", ret_count, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_retired", {31'd0, retired}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);

    // phase 1: run up to the stalled sw, then pull reset mid-request
    push_ret(4,  32'h04, 32'h0000_0005, 32'h0, 32'd1);
    push_ret(8,  32'h08, 32'hFFFF_FFFD, 32'h0, 32'd2);
    push_ret(12, 32'h0C, 32'h0000_0002, 32'h0, 32'd3);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (mem_req && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("sw_mem_timeout");
    chk("stall_ready_low", {31'd0, mem_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("reset_req_drop", {31'd0, mem_req}, 32'd0);
    chk("reset_pc", nextPC, 32'h0);
    chk("reset_cnt", ret_count, 32'h0);
    chk("ph1_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clock);

    // phase 2: full program with stalled data accesses
    push_ret(4,  32'h04,  32'h0000_0005, 32'h0, 32'd1);
    push_ret(8,  32'h08,  32'hFFFF_FFFD, 32'h0, 32'd2);
    push_ret(12, 32'h0C,  32'h0000_0002, 32'h0, 32'd3);
    push_ret(19, 32'h10,  32'h0000_0008, 32'h0, 32'd4);
    push_ret(27, 32'h14,  32'h0000_0008, 32'h2, 32'd5);
    push_ret(34, 32'h18,  32'h0000_0080, 32'h2, 32'd6);
    push_ret(37, 32'h24,  32'h0000_0024, 32'h2, 32'd7);
    push_ret(40, 32'h28,  32'h0000_003C, 32'h2, 32'd8);
    push_ret(43, 32'h30,  32'h0000_0030, 32'h2, 32'd9);
    push_ret(46, 32'h100, 32'h0000_0134, 32'h2, 32'd10);
    push_ret(53, 32'h104, 32'h0000_0080, 32'h2, 32'd11);
    push_ret(56, 32'h34,  32'h0000_0128, 32'h2, 32'd12);
    push_ret(60, 32'h38,  32'h0000_8001, 32'h2, 32'd13);
    push_ret(64, 32'h3C,  32'h0000_0001, 32'h2, 32'd14);
    push_ret(68, 32'h40,  32'h0000_0050, 32'h2, 32'd15);
    push_wr(32'h08, 32'h2);
    push_wr(32'h80, 32'h2);
    push_wr(32'h80, 32'h34);
    release_reset();

    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1;
      if (trap) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("trap_timeout");
    chk("trap_cycle", cyc, 32'd70);
    chk("exp_drained", exp_q.size(), 32'd0);
    chk("wr_drained", wr_q.size(), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      chk("trap_held", {31'd0, trap}, 32'd1);
      chk("trap_no_req", {31'd0, mem_req}, 32'd0);
    end
    chk("trap_cnt", ret_count, 32'd15);
    chk("trap_cnt_w2", {30'd0, u2_ret_count}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
